// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue and sequencing controller for the E-stage multiply/divide unit.
// It pulses start when a mult/div issues and then times the fixed latency.
// It commits HI/LO at the end of that latency and produces the D-stage stall
// for HI/LO consumers. A flush request (req) masks issue and the mthi/mtlo
// writes of the E-stage op. It never cancels an operation that is already
// running.
//
// Handshake: this block has no ready/valid back-pressure. valid_e qualifies
// op_e in the same cycle. start is a one-cycle pulse on which the datapath
// must latch its operands. hilo_we is a one-cycle pulse on which HI/LO must
// take the datapath result. stall_d is the only flow control: while it is
// high, the pipeline holds D and presents a bubble to E.
module mdu_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_e,
    input  logic [3:0]       op_e,
    input  logic             req,
    input  logic             md_use_d,
    output logic             start,
    output logic [1:0]       op_sel,
    output logic             busy,
    output logic [CNT_W-1:0] cnt,
    output logic             hilo_we,
    output logic             hi_we,
    output logic             lo_we,
    output logic             stall_d
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The count loaded at issue is the number of RUN cycles that follow the issue cycle.
    localparam logic [CNT_W-1:0] MULT_INIT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_sel_q, op_sel_d;

    logic e_ok;
    logic is_mul;
    logic is_div;
    logic issue;
    logic running;

    // Decode the E-stage op. A flushed or bubble instruction never issues and never writes.
    always_comb begin
        e_ok    = valid_e & ~req;
        is_mul  = (op_e == 4'd1) || (op_e == 4'd2);
        is_div  = (op_e == 4'd3) || (op_e == 4'd4);
        running = (state_q == RUN);
        issue   = e_ok & (is_mul | is_div) & ~running;
    end

    // Next-state logic. A mult/div seen while RUN is a stall-protocol violation; it is ignored.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_sel_d = op_sel_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d  = RUN;
                    cnt_d    = is_mul ? MULT_INIT : DIV_INIT;
                    op_sel_d = 2'(op_e - 4'd1);
                end
            end
            RUN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register. Reset has priority over an issue in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_sel_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_sel_q <= op_sel_d;
        end
    end

    // Output decode. busy covers the issue cycle, so a dependent op in D stalls from cycle T onward.
    always_comb begin
        start   = issue;
        busy    = issue | running;
        hilo_we = running & (cnt_q == CNT_ONE);
        hi_we   = e_ok & (op_e == 4'd7);
        lo_we   = e_ok & (op_e == 4'd8);
        stall_d = md_use_d & busy;
        cnt     = cnt_q;
        op_sel  = op_sel_q;
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: directed and random stimulus for mdu_issue_ctrl.
// The reference model does not follow the RTL's states. It records the
// absolute cycle at which the unit becomes free again, and derives busy,
// cnt and the commit cycle from that cycle with plain arithmetic.
module tb_mdu_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_e;
    logic [3:0]       op_e;
    logic             req;
    logic             md_use_d;
    logic             start;
    logic [1:0]       op_sel;
    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             hilo_we;
    logic             hi_we;
    logic             lo_we;
    logic             stall_d;

    // clock
    always #5 clk = ~clk;

    mdu_issue_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_e (valid_e),
        .op_e    (op_e),
        .req     (req),
        .md_use_d(md_use_d),
        .start   (start),
        .op_sel  (op_sel),
        .busy    (busy),
        .cnt     (cnt),
        .hilo_we (hilo_we),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .stall_d (stall_d)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         free_at  = 0;   // first cycle index at which the unit is idle again
    logic [1:0] op_sel_m = 2'd0;
    int         hilo_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs just after the rising edge, then check at the falling edge.
    // Finally advance the model across the next rising edge.
    task automatic step(input logic v, input logic [3:0] op, input logic rq,
                        input logic md, input logic rst);
        bit run, iss, exp_busy, exp_hilo;
        int exp_cnt;
        @(posedge clk);
        #1;
        valid_e  = v;
        op_e     = op;
        req      = rq;
        md_use_d = md;
        reset    = rst;
        @(negedge clk);
        run      = (cyc < free_at);
        iss      = v && !rq && (op >= 4'd1) && (op <= 4'd4) && !run;
        exp_busy = iss || run;
        exp_cnt  = run ? (free_at - cyc) : 0;
        exp_hilo = run && (cyc == free_at - 1);
        chk("start",   32'(start),   32'(iss));
        chk("busy",    32'(busy),    32'(exp_busy));
        chk("cnt",     32'(cnt),     32'(exp_cnt));
        chk("hilo_we", 32'(hilo_we), 32'(exp_hilo));
        chk("hi_we",   32'(hi_we),   32'(v && !rq && op == 4'd7));
        chk("lo_we",   32'(lo_we),   32'(v && !rq && op == 4'd8));
        chk("stall_d", 32'(stall_d), 32'(md && exp_busy));
        chk("op_sel",  32'(op_sel),  32'(op_sel_m));
        if (hilo_we === 1'b1) hilo_cnt++;
        if (rst) begin
            free_at  = 0;
            op_sel_m = 2'd0;
        end else if (iss) begin
            free_at  = cyc + ((op <= 4'd2) ? MULT_LAT : DIV_LAT);
            op_sel_m = 2'(op - 4'd1);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset
        reset    = 1'b1;
        valid_e  = 1'b0;
        op_e     = 4'd0;
        req      = 1'b0;
        md_use_d = 1'b0;
        repeat (3) @(posedge clk);

        // reset state
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // mult: busy T..T+4, one commit at T+4, then cnt runs 4,3,2,1,0
        hilo_cnt = 0;
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        idle(6);
        chk("mult_hilo_pulses", 32'(hilo_cnt), 32'd1);

        // divu, then mflo waiting in D; E sees bubbles while stalled
        hilo_cnt = 0;
        step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        chk("divu_hilo_pulses", 32'(hilo_cnt), 32'd1);
        chk("divu_op_sel", 32'(op_sel), 32'd3);

        // flush masks issue and mthi; unflushed mthi/mtlo write
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);

        // req during a running mult does not cancel it
        hilo_cnt = 0;
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("req_mid_hilo_pulses", 32'(hilo_cnt), 32'd1);

        // reset at T+3 of a div: no commit afterwards
        hilo_cnt = 0;
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(10);
        chk("reset_mid_hilo_pulses", 32'(hilo_cnt), 32'd0);

        // reset wins over a simultaneous issue
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        idle(2);

        // back-to-back mult then multu
        hilo_cnt = 0;
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        chk("b2b_op_sel_before", 32'(op_sel), 32'd0);
        idle(5);
        chk("b2b_hilo_pulses", 32'(hilo_cnt), 32'd2);
        chk("b2b_op_sel_after", 32'(op_sel), 32'd1);

        // stall-protocol violation: a new div during RUN is ignored
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
        idle(5);

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15) < 10 ? $urandom_range(1, 8) : $urandom_range(0, 15)),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 49) == 0));
        end

        // report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
